// File: rtl/uart_tx_scheduler.sv
// Arbitrates the uart_tx byte channel between command bytes and a periodic telemetry frame.
// Define UART_TELEM_CHECKSUM_EN to append a checksum byte (distance ^ status) to each frame.
module uart_tx_scheduler #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TELEM_HZ = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_ascii,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] distance,
    input  logic [5:0] direction,
    input  logic       no_red,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] overrun_count
);

    localparam int PERIOD = CLK_HZ / TELEM_HZ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD - 1);

`ifdef UART_TELEM_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMD_SEND,
        TEL_SEND
    } state_t;

    typedef enum logic {
        GRANT_CMD,
        GRANT_TEL
    } grant_t;

    state_t        state;
    state_t        state_next;
    grant_t        last_grant;
    logic [CW-1:0] tick_count;
    logic          tick;
    logic          tel_pending;
    logic [2:0]    idx;
    logic [2:0]    next_idx;
    logic [7:0]    next_byte;
    logic [7:0]    tx_data_q;
    logic [7:0]    overrun_q;
    logic [7:0]    snap_distance;
    logic [7:0]    snap_status;
`ifdef UART_TELEM_CHECKSUM_EN
    logic [7:0]    snap_checksum;
`endif
    logic          ready_c;
    logic          take_cmd;
    logic          start_tel;
    logic          byte_done;
    logic          frame_done;

    assign tick = (tick_count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Commands win unless the previous grant went to a command and telemetry is waiting.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        take_cmd   = 1'b0;
        start_tel  = 1'b0;
        byte_done  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                ready_c = !reset && !(tel_pending && last_grant == GRANT_CMD);
                if (cmd_valid && ready_c) begin
                    take_cmd   = 1'b1;
                    state_next = CMD_SEND;
                end else if (tel_pending) begin
                    start_tel  = 1'b1;
                    state_next = TEL_SEND;
                end
            end
            CMD_SEND: begin
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            TEL_SEND: begin
                if (tx_ready) begin
                    byte_done = 1'b1;
                    if (idx == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign next_idx = idx + 3'd1;

    always_comb begin
        next_byte = 8'h0A;
        case (next_idx)
            3'd1: next_byte = snap_distance;
            3'd2: next_byte = snap_status;
`ifdef UART_TELEM_CHECKSUM_EN
            3'd3: next_byte = snap_checksum;
`endif
            default: next_byte = 8'h0A;
        endcase
    end

    // A tick landing on the same cycle a frame starts re-arms pending without counting an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count  <= '0;
            tel_pending <= 1'b0;
            overrun_q   <= 8'h00;
        end else begin
            tick_count <= tick ? '0 : tick_count + CW'(1);
            if (tick) begin
                tel_pending <= 1'b1;
                if (tel_pending && !start_tel && overrun_q != 8'hFF) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end else if (start_tel) begin
                tel_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data_q     <= 8'h00;
            idx           <= 3'd0;
            last_grant    <= GRANT_TEL;
            snap_distance <= 8'h00;
            snap_status   <= 8'h00;
`ifdef UART_TELEM_CHECKSUM_EN
            snap_checksum <= 8'h00;
`endif
        end else begin
            if (take_cmd) begin
                tx_data_q <= cmd_ascii;
            end
            if (start_tel) begin
                snap_distance <= distance;
                snap_status   <= {1'b0, no_red, direction};
`ifdef UART_TELEM_CHECKSUM_EN
                snap_checksum <= distance ^ {1'b0, no_red, direction};
`endif
                idx       <= 3'd0;
                tx_data_q <= 8'h54;
            end
            if (byte_done && !frame_done) begin
                idx       <= next_idx;
                tx_data_q <= next_byte;
            end
            if (state == CMD_SEND && tx_ready) begin
                last_grant <= GRANT_CMD;
            end
            if (frame_done) begin
                last_grant <= GRANT_TEL;
            end
        end
    end

    assign cmd_ready     = ready_c;
    assign tx_data       = tx_data_q;
    assign tx_valid      = (state != IDLE);
    assign busy          = (state != IDLE);
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler (P = 100 cycles); frame length follows UART_TELEM_CHECKSUM_EN.
module tb_uart_tx_scheduler;

`ifdef UART_TELEM_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_ascii = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] distance = 8'h2A;
    logic [5:0] direction = 6'd12;
    logic       no_red = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic [7:0] overrun_count;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle = 0;
    logic [7:0] sb[$];

    uart_tx_scheduler #(
        .CLK_HZ   (1000),
        .TELEM_HZ (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_ascii     (cmd_ascii),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .distance      (distance),
        .direction     (direction),
        .no_red        (no_red),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, actual, expected);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [7:0] d, input logic [7:0] s, input int i);
        case (i)
            0: return 8'h54;
            1: return d;
            2: return s;
`ifdef UART_TELEM_CHECKSUM_EN
            3: return d ^ s;
`endif
            default: return 8'h0A;
        endcase
    endfunction

    task automatic push_frame(input logic [7:0] d, input logic [7:0] s);
        for (int i = 0; i < FRAME_LEN; i++) sb.push_back(frame_byte(d, s, i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic go_to(input int n);
        while (cycle < n) step();
    endtask

    task automatic reset_dut(input string tag);
        reset = 1'b1;
        step();
        check_output({tag, "_tx_valid"}, tx_valid, 0);
        check_output({tag, "_tx_data"}, tx_data, 8'h00);
        check_output({tag, "_cmd_ready"}, cmd_ready, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_overrun"}, overrun_count, 0);
        step();
        reset = 1'b0;
        cycle = 0;
    endtask

    // Every accepted output byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                check_output("sb_unexpected_byte", tx_data, 8'h00);
            end else begin
                check_output("sb_byte", tx_data, sb.pop_front());
            end
        end
    end

    initial begin
        reset_dut("por");

        // Single command, then an idle telemetry frame.
        go_to(20);
        cmd_ascii = 8'h46;
        cmd_valid = 1'b1;
        sb.push_back(8'h46);
        #1;
        check_output("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check_output("cmd_tx_valid", tx_valid, 1);
        check_output("cmd_tx_data", tx_data, 8'h46);
        step();
        check_output("cmd_busy_done", busy, 0);
        push_frame(8'h2A, 8'h0C);
        go_to(100);
        check_output("tel_not_yet", tx_valid, 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            go_to(101 + i);
            check_output("tel_valid", tx_valid, 1);
            check_output("tel_byte", tx_data, frame_byte(8'h2A, 8'h0C, i));
        end
        go_to(101 + FRAME_LEN);
        check_output("tel_idle_gap", tx_valid, 0);

        // Backpressure on the status byte; distance change mid-frame must not leak in.
        push_frame(8'h2A, 8'h0C);
        go_to(203);
        tx_ready = 1'b0;
        distance = 8'h77;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_output("bp_hold_data", tx_data, 8'h0C);
            check_output("bp_hold_valid", tx_valid, 1);
            step();
        end
        tx_ready = 1'b1;
        go_to(220);
        distance = 8'h2A;
        check_output("bp_sb_drained", sb.size(), 0);

        // Contention: command held across a tick alternates with the frame.
        reset_dut("contention");
        go_to(99);
        cmd_ascii = 8'h46;
        cmd_valid = 1'b1;
        sb.push_back(8'h46);
        push_frame(8'h2A, 8'h0C);
        sb.push_back(8'h46);
        sb.push_back(8'h46);
        go_to(101);
        #1;
        check_output("cont_tel_wins", cmd_ready, 0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            go_to(102 + i);
            check_output("cont_frame_cmd_ready", cmd_ready, 0);
            check_output("cont_frame_byte", tx_data, frame_byte(8'h2A, 8'h0C, i));
        end
        go_to(105 + FRAME_LEN);
        cmd_valid = 1'b0;
        go_to(110 + FRAME_LEN);
        check_output("cont_busy_done", busy, 0);
        check_output("cont_sb_drained", sb.size(), 0);

        // Overrun: sink stalled over three ticks, then released.
        reset_dut("overrun");
        tx_ready = 1'b0;
        push_frame(8'h2A, 8'h0C);
        push_frame(8'h55, 8'h0C);
        go_to(150);
        distance = 8'h55;
        go_to(299);
        check_output("ovr_before", overrun_count, 0);
        go_to(300);
        check_output("ovr_after", overrun_count, 1);
        go_to(350);
        tx_ready = 1'b1;
        go_to(398);
        check_output("ovr_busy_done", busy, 0);
        check_output("ovr_count_held", overrun_count, 1);
        check_output("ovr_sb_drained", sb.size(), 0);

        // Reset while byte 3 is presented; partial frame is abandoned.
        sb.push_back(8'h54);
        sb.push_back(8'h55);
        sb.push_back(8'h0C);
        go_to(404);
        check_output("mid_byte3", tx_data, frame_byte(8'h55, 8'h0C, 3));
        reset_dut("midframe");
        push_frame(8'h55, 8'h0C);
        go_to(100);
        check_output("mid_not_yet", tx_valid, 0);
        go_to(101);
        check_output("mid_restart_valid", tx_valid, 1);
        check_output("mid_restart_byte", tx_data, 8'h54);
        go_to(110);
        check_output("final_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Arbitrates the single `uart_tx` byte channel on `clk_50` between drive-command bytes from `command_translator` and a periodic telemetry frame. The telemetry frame carries the filtered ultrasonic distance and the filtered direction/no-red status. The block sits between `command_translator` and `uart_tx`. Command bytes are forwarded with priority, telemetry frames are sent atomically, and round-robin alternation prevents either source from starving the other.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency.
- `TELEM_HZ`, 4: telemetry frame rate; tick period `P = CLK_HZ/TELEM_HZ` cycles.
- `clk`  in  1  system clock (`clk_50`); single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_ascii`  in  8  command byte from `command_translator`.
- `cmd_valid`  in  1  command byte available.
- `cmd_ready`  out  1  scheduler accepts the command this cycle; feeds the translator's `uart_ready`.
- `distance`  in  8  averaged ultrasonic distance.
- `direction`  in  6  averaged direction (0..25).
- `no_red`  in  1  no red target detected.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  `uart_tx` can accept a byte.
- `busy`  out  1  state is not IDLE.
- `overrun_count`  out  8  saturating count of dropped telemetry ticks.

## Operation
- Tick counter:
  - Counts 0..P-1 and wraps.
  - Pulses `tick` for one cycle on the wrap.
  - The first tick occurs P cycles after reset release.
- `tel_pending`:
  - Set by `tick`.
  - Cleared when a frame starts.
  - If `tick` arrives while `tel_pending` is already 1, `overrun_count` increments (saturating at 255).
- Grant flag `last_grant` ∈ {CMD, TEL}; reset value is TEL.
- States:
  - **IDLE:**
    - `cmd_ready = !reset && !(tel_pending && last_grant==CMD)`.
    - If `cmd_valid && cmd_ready`: latch `cmd_ascii` and go to CMD_SEND.
    - Else if `tel_pending`: snapshot `distance`, `{1'b0,no_red,direction}` and the checksum; clear `tel_pending`; set `idx=0`; go to TEL_SEND.
  - **CMD_SEND:**
    - `tx_valid=1`, `tx_data` = latched command.
    - On `tx_valid && tx_ready`: set `last_grant=CMD` and go to IDLE.
  - **TEL_SEND:**
    - `tx_valid=1`, `tx_data=frame[idx]`.
    - On handshake: `idx++`.
    - After the last byte: set `last_grant=TEL` and go to IDLE.
- Frame bytes:
  - 0x54 ('T')
  - distance
  - status
  - checksum = distance ^ status (see Configuration)
  - 0x0A
- Frames are atomic. A command arriving mid-frame waits with `cmd_ready=0`.
- Snapshot inputs are frozen for the whole frame; input changes mid-frame do not affect it.
- A tick during TEL_SEND sets `tel_pending` for the next frame; this is not an overrun.
- `cmd_ready` is 0 outside IDLE.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0x00`, `cmd_ready=0` while `reset` is high, `busy=0`, `overrun_count=0`, tick counter 0, `tel_pending=0`, state IDLE.
- Reset mid-operation: the frame or command is abandoned and the next cycle has `tx_valid=0`; no partial frame resumes.
- Command latency: accepted at cycle N, `tx_valid` high at cycle N+1.
- Frame start: decided at cycle N, byte 0 presented at cycle N+1.
- `tx_data`/`tx_valid` are registered and held stable until `tx_valid && tx_ready`.
- With `tx_ready` constantly 1, frame bytes go out on consecutive cycles.
- After the last handshake there is one IDLE cycle before the next grant.
- Simultaneous `cmd_valid` and `tel_pending` in IDLE:
  - Command wins if `last_grant==TEL`.
  - Telemetry wins if `last_grant==CMD`.
- Simultaneous `tick` and frame start in the same cycle: `tel_pending` ends at 1 and no overrun is counted.

## Configuration
- `UART_TELEM_CHECKSUM_EN`:
  - Defined: the frame is 5 bytes (T, distance, status, checksum, LF).
  - Undefined: the frame is 4 bytes (T, distance, status, LF) and no checksum logic is synthesised.
- All other behaviour is identical in both cases.

## Test plan
All scenarios use `CLK_HZ=1000`, `TELEM_HZ=10` (P=100) and the macro defined unless stated.
- **Idle telemetry:** distance=0x2A, direction=12, no_red=0, `tx_ready=1` → cycles 101..105 carry 0x54, 0x2A, 0x0C, 0x26, 0x0A. Without the macro: 0x54, 0x2A, 0x0C, 0x0A.
- **Single command:** `cmd_valid` with 0x46 at cycle 20 → `cmd_ready=1` at cycle 20; `tx_valid` with 0x46 at cycle 21; `busy` 0 by cycle 22.
- **Backpressure:** `tx_ready` low for 10 cycles while the status byte is presented → `tx_data` stays 0x0C with `tx_valid=1` throughout; the frame completes correctly after release.
- **Contention:** `cmd_valid` held high (0x46) across a tick → output is command, full 5-byte frame, command, command…; `cmd_ready=0` during the frame.
- **Overrun:** `tx_ready` low from cycle 0 to 350 → `overrun_count=1` after the tick at cycle 300. After release, the stuck frame finishes, then exactly one more frame is sent.
- **Reset mid-frame:** assert `reset` while byte 3 is presented → `tx_valid=0` and `overrun_count=0` next cycle; the next frame starts with 0x54, P cycles after reset release.
